// File: rtl/spi_arb_pkg.sv
// Shared types and constants for the SPI master arbiter.
package spi_arb_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    GRANT = 3'd1,
    START = 3'd2,
    WAIT  = 3'd3,
    DONE  = 3'd4
  } arb_state_t;

  localparam int DEFAULT_N_REQ   = 4;
  localparam int DEFAULT_TIMEOUT = 1024;

  // The counter has to hold the value TIMEOUT itself, hence the +1.
  function automatic int cnt_width(input int timeout);
    return $clog2(timeout + 1);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin selector: the index after last_winner has top priority,
// ascending with wrap. Purely combinational, one-hot (or zero) grant.
module rr_arbiter #(
  parameter int N_REQ = 4,
  parameter int IDX_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] last_winner,
  output logic [N_REQ-1:0] grant
);

  logic [IDX_W-1:0]   start;
  logic [2*N_REQ-1:0] doubled;
  logic [N_REQ-1:0]   rotated;
  logic [N_REQ-1:0]   rot_grant;
  logic [2*N_REQ-1:0] grant_doubled;

  // Rotate the request vector so the top-priority index sits at bit 0,
  // keep the lowest set bit, then rotate that back into place.
  always_comb begin
    if (last_winner == IDX_W'(N_REQ - 1)) begin
      start = '0;
    end else begin
      start = last_winner + 1'b1;
    end
    doubled       = {req, req};
    rotated       = N_REQ'(doubled >> start);
    rot_grant     = rotated & (-rotated);
    grant_doubled = {rot_grant, rot_grant} << start;
    grant         = grant_doubled[2*N_REQ-1:N_REQ];
  end

endmodule

// File: rtl/spi_master_arbiter.sv
// Shares one spi_master among N_REQ requesters: round-robin grant, one
// byte transfer per grant, with a timeout that aborts a stuck transfer.
module spi_master_arbiter
  import spi_arb_pkg::*;
#(
  parameter int N_REQ   = DEFAULT_N_REQ,
  parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [N_REQ-1:0]     req,
  input  logic [8*N_REQ-1:0]   req_d,
  output logic [N_REQ-1:0]     gnt,
  output logic [N_REQ-1:0]     done,
  output logic                 err,
  output logic [7:0]           rsp_q,
  output logic                 m_starttx,
  output logic [7:0]           m_d,
  input  logic [7:0]           m_q,
  input  logic                 m_finished
);

  localparam int IDX_W = $clog2(N_REQ);
  localparam int CNT_W = cnt_width(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  arb_state_t       state;
  logic [IDX_W-1:0] last_winner;
  logic [IDX_W-1:0] win_idx_q;
  logic [CNT_W-1:0] cnt;

  logic [N_REQ-1:0] arb_grant;
  logic [IDX_W-1:0] arb_idx;
  logic [7:0]       arb_data;

  rr_arbiter #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_rr (
    .req         (req),
    .last_winner (last_winner),
    .grant       (arb_grant)
  );

  // Turn the one-hot grant into an index and pick the winner's TX byte.
  always_comb begin
    arb_idx  = '0;
    arb_data = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (arb_grant[i]) begin
        arb_idx  = IDX_W'(i);
        arb_data = req_d[8*i +: 8];
      end
    end
  end

  // Transfer FSM; every output is registered and driven from here.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      gnt         <= '0;
      done        <= '0;
      err         <= 1'b0;
      rsp_q       <= '0;
      m_starttx   <= 1'b0;
      m_d         <= '0;
      cnt         <= '0;
      win_idx_q   <= '0;
      last_winner <= IDX_W'(N_REQ - 1);
    end else begin
      case (state)
        IDLE: begin
          if (|req) begin
            gnt       <= arb_grant;
            win_idx_q <= arb_idx;
            m_d       <= arb_data;
            state     <= GRANT;
          end
        end
        GRANT: begin
          m_starttx <= 1'b1;
          state     <= START;
        end
        START: begin
          m_starttx <= 1'b0;
          cnt       <= '0;
          state     <= WAIT;
        end
        WAIT: begin
          if (cnt != CNT_MAX) begin
            cnt <= cnt + 1'b1;
          end
          if (m_finished) begin
            rsp_q <= m_q;
            err   <= 1'b0;
            done  <= gnt;
            state <= DONE;
          end else if (cnt == CNT_LAST) begin
            rsp_q <= 8'h00;
            err   <= 1'b1;
            done  <= gnt;
            state <= DONE;
          end
        end
        DONE: begin
          done        <= '0;
          err         <= 1'b0;
          gnt         <= '0;
          last_winner <= win_idx_q;
          state       <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_master_arbiter.sv
// Directed bench for spi_master_arbiter: one instance with the default
// timeout for the functional cases, one with TIMEOUT=16 for timeout cases.
module tb_spi_master_arbiter;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;

  logic [3:0]  req = '0;
  logic [31:0] req_d = '0;
  logic [3:0]  gnt, done;
  logic        err, m_starttx;
  logic [7:0]  rsp_q, m_d;
  logic [7:0]  m_q = '0;
  logic        m_finished = 1'b0;

  logic [3:0]  req_t = '0;
  logic [31:0] req_d_t = '0;
  logic [3:0]  gnt_t, done_t;
  logic        err_t, m_starttx_t;
  logic [7:0]  rsp_q_t, m_d_t;
  logic [7:0]  m_q_t = '0;
  logic        m_finished_t = 1'b0;

  int checks = 0;
  int errors = 0;

  spi_master_arbiter #(.N_REQ(4), .TIMEOUT(1024)) dut (
    .clk(clk), .reset_n(reset_n), .req(req), .req_d(req_d),
    .gnt(gnt), .done(done), .err(err), .rsp_q(rsp_q),
    .m_starttx(m_starttx), .m_d(m_d), .m_q(m_q), .m_finished(m_finished)
  );

  spi_master_arbiter #(.N_REQ(4), .TIMEOUT(16)) dut_t (
    .clk(clk), .reset_n(reset_n), .req(req_t), .req_d(req_d_t),
    .gnt(gnt_t), .done(done_t), .err(err_t), .rsp_q(rsp_q_t),
    .m_starttx(m_starttx_t), .m_d(m_d_t), .m_q(m_q_t), .m_finished(m_finished_t)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  // Hard stop in case something stalls outside the bounded waits.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=stalled expected=finished");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Advance until the main instance raises m_starttx, bounded.
  task automatic applyStimulus(input string tag);
    int n = 0;
    while (m_starttx !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    checkOutput(tag, {31'd0, m_starttx}, 32'd1);
  endtask

  initial begin
    // Reset values
    repeat (3) tick();
    checkOutput("rst_gnt", {28'd0, gnt}, 32'h0);
    checkOutput("rst_done", {28'd0, done}, 32'h0);
    checkOutput("rst_err", {31'd0, err}, 32'h0);
    checkOutput("rst_rsp_q", {24'd0, rsp_q}, 32'h0);
    checkOutput("rst_starttx", {31'd0, m_starttx}, 32'h0);
    checkOutput("rst_m_d", {24'd0, m_d}, 32'h0);
    reset_n = 1'b1;

    // Single request, master answers 20 cycles after start
    req = 4'b0001;
    req_d[7:0] = 8'hA5;
    tick();
    checkOutput("single_gnt", {28'd0, gnt}, 32'h1);
    checkOutput("single_start_early", {31'd0, m_starttx}, 32'h0);
    tick();
    checkOutput("single_start_2cyc", {31'd0, m_starttx}, 32'h1);
    checkOutput("single_m_d", {24'd0, m_d}, 32'hA5);
    tick();
    checkOutput("single_start_pulse", {31'd0, m_starttx}, 32'h0);
    repeat (19) tick();
    checkOutput("single_m_d_stable", {24'd0, m_d}, 32'hA5);
    checkOutput("single_gnt_stable", {28'd0, gnt}, 32'h1);
    checkOutput("single_no_done_yet", {28'd0, done}, 32'h0);
    m_finished = 1'b1;
    m_q = 8'h3C;
    tick();
    m_finished = 1'b0;
    req = 4'b0000;
    checkOutput("single_done", {28'd0, done}, 32'h1);
    checkOutput("single_rsp_q", {24'd0, rsp_q}, 32'h3C);
    checkOutput("single_err", {31'd0, err}, 32'h0);
    checkOutput("single_gnt_in_done", {28'd0, gnt}, 32'h1);
    tick();
    checkOutput("single_done_pulse", {28'd0, done}, 32'h0);
    checkOutput("single_gnt_release", {28'd0, gnt}, 32'h0);
    checkOutput("single_rsp_hold", {24'd0, rsp_q}, 32'h3C);

    // Contention from reset: all four requesters held high
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    req = 4'b1111;
    req_d = 32'h13121110;
    for (int k = 0; k < 5; k++) begin
      applyStimulus($sformatf("rr_start_%0d", k));
      checkOutput($sformatf("rr_gnt_%0d", k), {28'd0, gnt}, 32'd1 << (k % 4));
      checkOutput($sformatf("rr_m_d_%0d", k), {24'd0, m_d}, 32'h10 + (k % 4));
      tick();
      m_finished = 1'b1;
      m_q = 8'hC0 + 8'(k);
      tick();
      m_finished = 1'b0;
      checkOutput($sformatf("rr_done_%0d", k), {28'd0, done}, 32'd1 << (k % 4));
      checkOutput($sformatf("rr_rsp_%0d", k), {24'd0, rsp_q}, 32'hC0 + k);
      if (k == 4) req = 4'b0000;
      tick();
      checkOutput($sformatf("rr_one_done_%0d", k), {28'd0, done}, 32'h0);
    end

    // Stray m_finished in IDLE
    m_finished = 1'b1;
    m_q = 8'hEE;
    tick();
    m_finished = 1'b0;
    checkOutput("stray_done", {28'd0, done}, 32'h0);
    checkOutput("stray_gnt", {28'd0, gnt}, 32'h0);
    tick();
    checkOutput("stray_done2", {28'd0, done}, 32'h0);
    checkOutput("stray_rsp_hold", {24'd0, rsp_q}, 32'hC4);

    // Requester drops req during WAIT; transfer still completes
    req = 4'b0100;
    req_d[23:16] = 8'h5A;
    applyStimulus("drop_start");
    checkOutput("drop_gnt", {28'd0, gnt}, 32'h4);
    checkOutput("drop_m_d", {24'd0, m_d}, 32'h5A);
    tick();
    req = 4'b0000;
    repeat (3) tick();
    checkOutput("drop_gnt_held", {28'd0, gnt}, 32'h4);
    m_finished = 1'b1;
    m_q = 8'h77;
    tick();
    m_finished = 1'b0;
    checkOutput("drop_done", {28'd0, done}, 32'h4);
    checkOutput("drop_rsp", {24'd0, rsp_q}, 32'h77);
    tick();

    // Reset in the middle of WAIT
    req = 4'b1000;
    req_d[31:24] = 8'hC3;
    applyStimulus("rstmid_start");
    checkOutput("rstmid_gnt", {28'd0, gnt}, 32'h8);
    tick();
    reset_n = 1'b0;
    #1;
    checkOutput("rstmid_gnt_clr", {28'd0, gnt}, 32'h0);
    checkOutput("rstmid_rsp_clr", {24'd0, rsp_q}, 32'h0);
    checkOutput("rstmid_m_d_clr", {24'd0, m_d}, 32'h0);
    checkOutput("rstmid_err_clr", {31'd0, err}, 32'h0);
    for (int c = 0; c < 3; c++) begin
      tick();
      checkOutput($sformatf("rstmid_no_done_%0d", c), {28'd0, done}, 32'h0);
    end
    reset_n = 1'b1;
    req = 4'b1001;
    req_d[7:0] = 8'h11;
    tick();
    checkOutput("rstmid_prio0_gnt", {28'd0, gnt}, 32'h1);
    checkOutput("rstmid_prio0_m_d", {24'd0, m_d}, 32'h11);
    tick();
    tick();
    m_finished = 1'b1;
    m_q = 8'h42;
    tick();
    m_finished = 1'b0;
    req = 4'b0000;
    checkOutput("rstmid_after_done", {28'd0, done}, 32'h1);
    tick();

    // Timeout with a master that never finishes (TIMEOUT=16)
    req_t = 4'b0010;
    req_d_t[15:8] = 8'hEE;
    tick();
    checkOutput("to_gnt", {28'd0, gnt_t}, 32'h2);
    checkOutput("to_m_d", {24'd0, m_d_t}, 32'hEE);
    tick();
    checkOutput("to_start", {31'd0, m_starttx_t}, 32'h1);
    tick();
    repeat (15) tick();
    checkOutput("to_no_done_15", {28'd0, done_t}, 32'h0);
    tick();
    req_t = 4'b0000;
    checkOutput("to_done_16", {28'd0, done_t}, 32'h2);
    checkOutput("to_err", {31'd0, err_t}, 32'h1);
    checkOutput("to_rsp", {24'd0, rsp_q_t}, 32'h0);
    tick();
    checkOutput("to_err_clear", {31'd0, err_t}, 32'h0);

    // m_finished in the same cycle as the timeout: finish wins
    req_t = 4'b0010;
    tick();
    tick();
    checkOutput("coll_start", {31'd0, m_starttx_t}, 32'h1);
    tick();
    repeat (15) tick();
    m_finished_t = 1'b1;
    m_q_t = 8'h9B;
    tick();
    m_finished_t = 1'b0;
    req_t = 4'b0000;
    checkOutput("coll_done", {28'd0, done_t}, 32'h2);
    checkOutput("coll_err", {31'd0, err_t}, 32'h0);
    checkOutput("coll_rsp", {24'd0, rsp_q_t}, 32'h9B);
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
